controle_bcd_sequencial: RTL and testbench
==========================================

# controle_bcd_sequencial

Multi-cycle, handshaked binary-to-BCD converter controller for the processor's 7-segment output path. It accepts a signed value from the OUT-instruction datapath on a start pulse and sequences a shift-and-add-3 (double-dabble) conversion one bit per clock. It then publishes sign plus hundreds/tens/units digits to the display decoders. It replaces a purely combinational conversion loop with a small FSM, so the display path no longer limits the CPU critical path.

## Interface

Parameters:
- LARGURA, 8: number of low bits of `numero` treated as a two's-complement value. Legal range is 2..10; the result always fits 3 digits.

Ports:
- clock  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-low reset: sampled on the rising edge of `clock`; 0 = reset
- inicio  input  1  start request; sampled only in state OCIOSO
- numero  input  32  source value; only bits [LARGURA-1:0] are used, bits above are ignored
- ocupado  output  1  registered; 1 while in DESLOCA or FIM
- pronto  output  1  registered; one-cycle pulse when new digits are published
- sinal  output  1  sign of the published result; 1 = negative
- centena  output  4  hundreds digit, 0..5
- dezena  output  4  tens digit, 0..9
- unidade  output  4  units digit, 0..9

## Operation

- FSM states are OCIOSO, DESLOCA and FIM.
- **OCIOSO, `inicio`=1 at the edge:**
  - Latch `s` = numero[LARGURA-1] into an internal sign register.
  - Latch the magnitude into the shift register. The magnitude is numero[LARGURA-1:0] if `s`=0, else its two's complement computed in LARGURA bits, zero-extended by one bit so that the most negative value yields 2^(LARGURA-1).
  - Clear the scratch BCD registers.
  - Load bit counter = LARGURA-1, set `ocupado`=1, go to DESLOCA.
- **OCIOSO, `inicio`=0:** remain in OCIOSO and hold all outputs.
- **DESLOCA, each edge:**
  - Add 3 to every scratch digit that is ≥5.
  - Then shift {centena,dezena,unidade,magnitude} left by 1.
  - If counter==0, go to FIM; else decrement the counter.
- **FIM, one edge:**
  - Copy scratch digits and the latched sign to the outputs.
  - Set `pronto`=1 and `ocupado`=0, go to OCIOSO.
- `pronto` deasserts on the next edge unconditionally.
- Outputs hold the last published result until the next FIM. They never show partial results.
- Zero result: if the magnitude is 0, `sinal`=0. This is automatic, since the MSB is 0.
- `inicio` seen in DESLOCA or FIM is ignored. It is not queued.
- **Reset (`reset`=0 at an edge), any state, including mid-conversion:**
  - Go to OCIOSO and clear the scratch registers and counter.
  - `ocupado`=0, `pronto`=0, `sinal`=0, all digits 0.
  - An aborted conversion never produces `pronto`.

## Timing

- Reset values: `ocupado`=0, `pronto`=0, `sinal`=0, `centena`=`dezena`=`unidade`=0, state OCIOSO.
- Latency: `inicio` sampled at edge E0, shifts on edges E1..E_LARGURA, FIM at edge E_LARGURA+1. New digits and `pronto`=1 are visible after edge E(LARGURA+1). With the default parameter this is 9 cycles.
- `ocupado` is high from after E0 through E_LARGURA, and low after E_LARGURA+1.
- Throughput with `inicio` held high: a new start at E(LARGURA+2), giving one result every LARGURA+2 cycles (10 with the default).
- `numero` is sampled only at the start edge. Changes during conversion have no effect.
- No combinational path from inputs to outputs.

## Test plan

1. Reset: hold `reset`=0 for 2 edges with random inputs, then release. All outputs read 0 and the FSM is idle.
2. Positive conversion: `numero`=32'd45, one-cycle `inicio`. The bench must see:
   - `sinal`=0, `centena`=0, `dezena`=4, `unidade`=5;
   - `pronto` high exactly 1 cycle, 9 cycles after start;
   - `ocupado` high for 9 cycles.
3. Negative and boundary values (default LARGURA):
   - 8'hFF gives 1/0/0/1.
   - 8'h80 gives 1/1/2/8.
   - 8'h7F gives 0/1/2/7.
   - 8'h00 gives 0/0/0/0.
   - 32'hFFFF_FF05 gives 0/0/0/5, because the upper bits are ignored.
4. Busy and back-to-back starts:
   - Pulse `inicio` with value 12. While `ocupado`, pulse `inicio` with 99 and also change `numero`. The result is 0/0/1/2 with one `pronto` only.
   - Then hold `inicio` high with 33. `pronto` pulses every 10 cycles and the outputs hold the previous value between pulses.
5. Mid-conversion reset: start a conversion of 8'h9C (-100). Assert `reset`=0 at the 4th DESLOCA edge. All outputs clear, no `pronto` ever appears for that request, and a following start with 8'd7 yields 0/0/0/7 with normal latency.
6. Parameter sweep at LARGURA=4 and LARGURA=10: exhaustively compare every input value against a reference model. Latency is LARGURA+1 cycles. For LARGURA=10, 10'h200 gives 1/5/1/2.

Source files
------------

// File: rtl/controle_bcd_sequencial_if.sv
`default_nettype none
// ============================================================================
// controle_bcd_sequencial_if : start/value request and BCD result bundle
// Revision: 1.0
// ============================================================================
interface controle_bcd_sequencial_if;
   logic        inicio;
   logic [31:0] numero;
   logic        ocupado;
   logic        pronto;
   logic        sinal;
   logic [3:0]  centena;
   logic [3:0]  dezena;
   logic [3:0]  unidade;

   modport master (
      output inicio, numero,
      input  ocupado, pronto, sinal, centena, dezena, unidade
   );

   modport slave (
      input  inicio, numero,
      output ocupado, pronto, sinal, centena, dezena, unidade
   );
endinterface
`default_nettype wire

// File: rtl/controle_bcd_sequencial.sv
`default_nettype none
// ============================================================================
// controle_bcd_sequencial : sequential double-dabble binary-to-BCD controller
// Revision: 1.0
// ============================================================================
module controle_bcd_sequencial #(
   parameter int LARGURA = 8
) (
   input  logic                        clock,
   input  logic                        reset,
   controle_bcd_sequencial_if.slave    bus
);

   localparam int CW = (LARGURA > 1) ? $clog2(LARGURA) : 1;

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      DESLOCA = 2'd1,
      FIM     = 2'd2
   } estado_t;

   estado_t            estado_q, estado_d;
   logic [CW-1:0]      cont_q, cont_d;
   logic [LARGURA-1:0] mag_q, mag_d;
   logic               sinal_lat_q, sinal_lat_d;
   logic [3:0]         cen_q, cen_d;
   logic [3:0]         dez_q, dez_d;
   logic [3:0]         uni_q, uni_d;

   logic               ocupado_q, ocupado_d;
   logic               pronto_q, pronto_d;
   logic               sinal_q, sinal_d;
   logic [3:0]         centena_q, centena_d;
   logic [3:0]         dezena_q, dezena_d;
   logic [3:0]         unidade_q, unidade_d;

   logic [LARGURA-1:0] valor;
   logic [LARGURA-1:0] valor_neg;
   logic [3:0]         cen_aj, dez_aj, uni_aj;
   logic               unused_bits;

   function automatic logic [3:0] ajusta(input logic [3:0] x);
      return (x >= 4'd5) ? (x + 4'd3) : x;
   endfunction

   assign valor     = bus.numero[LARGURA-1:0];
   // Negation stays in LARGURA bits: the most negative input maps to 2^(LARGURA-1).
   assign valor_neg = (~valor) + LARGURA'(1);

   assign cen_aj = ajusta(cen_q);
   assign dez_aj = ajusta(dez_q);
   assign uni_aj = ajusta(uni_q);

   assign unused_bits = ^{bus.numero[31:LARGURA], cen_aj[3]};

   always_comb begin
      estado_d    = estado_q;
      cont_d      = cont_q;
      mag_d       = mag_q;
      sinal_lat_d = sinal_lat_q;
      cen_d       = cen_q;
      dez_d       = dez_q;
      uni_d       = uni_q;
      ocupado_d   = ocupado_q;
      pronto_d    = 1'b0;
      sinal_d     = sinal_q;
      centena_d   = centena_q;
      dezena_d    = dezena_q;
      unidade_d   = unidade_q;

      case (estado_q)
         OCIOSO: begin
            if (bus.inicio) begin
               sinal_lat_d = valor[LARGURA-1];
               mag_d       = valor[LARGURA-1] ? valor_neg : valor;
               cen_d       = 4'd0;
               dez_d       = 4'd0;
               uni_d       = 4'd0;
               cont_d      = CW'(LARGURA - 1);
               ocupado_d   = 1'b1;
               estado_d    = DESLOCA;
            end
         end

         DESLOCA: begin
            cen_d = {cen_aj[2:0], dez_aj[3]};
            dez_d = {dez_aj[2:0], uni_aj[3]};
            uni_d = {uni_aj[2:0], mag_q[LARGURA-1]};
            mag_d = {mag_q[LARGURA-2:0], 1'b0};
            if (cont_q == '0) begin
               estado_d = FIM;
            end else begin
               cont_d = cont_q - CW'(1);
            end
         end

         FIM: begin
            // Publish only complete results so the display never sees partial digits.
            sinal_d   = sinal_lat_q;
            centena_d = cen_q;
            dezena_d  = dez_q;
            unidade_d = uni_q;
            pronto_d  = 1'b1;
            ocupado_d = 1'b0;
            estado_d  = OCIOSO;
         end

         default: begin
            estado_d = OCIOSO;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         estado_q    <= OCIOSO;
         cont_q      <= '0;
         mag_q       <= '0;
         sinal_lat_q <= 1'b0;
         cen_q       <= 4'd0;
         dez_q       <= 4'd0;
         uni_q       <= 4'd0;
         ocupado_q   <= 1'b0;
         pronto_q    <= 1'b0;
         sinal_q     <= 1'b0;
         centena_q   <= 4'd0;
         dezena_q    <= 4'd0;
         unidade_q   <= 4'd0;
      end else begin
         estado_q    <= estado_d;
         cont_q      <= cont_d;
         mag_q       <= mag_d;
         sinal_lat_q <= sinal_lat_d;
         cen_q       <= cen_d;
         dez_q       <= dez_d;
         uni_q       <= uni_d;
         ocupado_q   <= ocupado_d;
         pronto_q    <= pronto_d;
         sinal_q     <= sinal_d;
         centena_q   <= centena_d;
         dezena_q    <= dezena_d;
         unidade_q   <= unidade_d;
      end
   end

   assign bus.ocupado = ocupado_q;
   assign bus.pronto  = pronto_q;
   assign bus.sinal   = sinal_q;
   assign bus.centena = centena_q;
   assign bus.dezena  = dezena_q;
   assign bus.unidade = unidade_q;

endmodule
`default_nettype wire

// File: tb/tb_controle_bcd_sequencial.sv
`default_nettype none
// ============================================================================
// tb_controle_bcd_sequencial : directed bench for the sequential BCD controller
// Revision: 1.0
// ============================================================================
module tb_controle_bcd_sequencial;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clock = ~clock;

   controle_bcd_sequencial_if bus8 ();
   controle_bcd_sequencial_if bus4 ();
   controle_bcd_sequencial_if bus10 ();

   controle_bcd_sequencial #(.LARGURA(8))  dut8  (.clock(clock), .reset(reset), .bus(bus8));
   controle_bcd_sequencial #(.LARGURA(4))  dut4  (.clock(clock), .reset(reset), .bus(bus4));
   controle_bcd_sequencial #(.LARGURA(10)) dut10 (.clock(clock), .reset(reset), .bus(bus10));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input int inst, input logic ini, input logic [31:0] val);
      case (inst)
         4:       begin bus4.inicio  = ini; bus4.numero  = val; end
         10:      begin bus10.inicio = ini; bus10.numero = val; end
         default: begin bus8.inicio  = ini; bus8.numero  = val; end
      endcase
   endtask

   function automatic logic [12:0] res(input int inst);
      case (inst)
         4:       return {bus4.sinal, bus4.centena, bus4.dezena, bus4.unidade};
         10:      return {bus10.sinal, bus10.centena, bus10.dezena, bus10.unidade};
         default: return {bus8.sinal, bus8.centena, bus8.dezena, bus8.unidade};
      endcase
   endfunction

   function automatic logic get_pronto(input int inst);
      case (inst)
         4:       return bus4.pronto;
         10:      return bus10.pronto;
         default: return bus8.pronto;
      endcase
   endfunction

   function automatic logic get_ocupado(input int inst);
      case (inst)
         4:       return bus4.ocupado;
         10:      return bus10.ocupado;
         default: return bus8.ocupado;
      endcase
   endfunction

   // Reference: plain arithmetic on the sign-extended value.
   function automatic logic [12:0] modelo(input int l, input int v);
      int   vm, m;
      logic s;
      vm = v & ((1 << l) - 1);
      s  = ((vm >> (l - 1)) & 1) != 0;
      m  = s ? ((1 << l) - vm) : vm;
      return {s, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
   endfunction

   task automatic convert(input int inst, input logic [31:0] val, output int lat, output int busy);
      drive(inst, 1'b1, val);
      tick();
      drive(inst, 1'b0, val);
      lat  = 0;
      busy = 0;
      while (!get_pronto(inst) && lat < 40) begin
         if (get_ocupado(inst)) busy++;
         tick();
         lat++;
      end
   endtask

   logic [31:0] vec  [5] = '{32'h0000_00FF, 32'h0000_0080, 32'h0000_007F, 32'h0000_0000, 32'hFFFF_FF05};
   logic [12:0] vexp [5] = '{13'h1001, 13'h1128, 13'h0127, 13'h0000, 13'h0005};

   initial begin
      int lat, busy, n, pulses;

      // Reset with random inputs
      drive(8,  1'($urandom_range(0, 1)), $urandom);
      drive(4,  1'($urandom_range(0, 1)), $urandom);
      drive(10, 1'($urandom_range(0, 1)), $urandom);
      tick();
      tick();
      drive(8, 1'b0, 32'd0);
      drive(4, 1'b0, 32'd0);
      drive(10, 1'b0, 32'd0);
      reset = 1'b1;
      check("reset_res8",  32'(res(8)),  32'h0);
      check("reset_res4",  32'(res(4)),  32'h0);
      check("reset_res10", 32'(res(10)), 32'h0);
      check("reset_flags8", {30'd0, bus8.ocupado, bus8.pronto}, 32'h0);
      tick();
      check("idle_after_reset", {30'd0, bus8.ocupado, bus8.pronto}, 32'h0);

      // Positive conversion
      convert(8, 32'd45, lat, busy);
      check("pos45_res", 32'(res(8)), 32'h0045);
      check("pos45_lat", lat, 9);
      check("pos45_busy", busy, 9);
      check("pos45_ocupado_low", 32'(bus8.ocupado), 32'd0);
      tick();
      check("pos45_pronto_1cyc", 32'(bus8.pronto), 32'd0);
      check("pos45_hold", 32'(res(8)), 32'h0045);

      // Negative and boundary values
      for (int i = 0; i < 5; i++) begin
         convert(8, vec[i], lat, busy);
         check($sformatf("vec%0d_res", i), 32'(res(8)), 32'(vexp[i]));
         check($sformatf("vec%0d_lat", i), lat, 9);
      end

      // Start request while busy is ignored
      drive(8, 1'b1, 32'd12);
      tick();
      drive(8, 1'b0, 32'd12);
      tick();
      tick();
      drive(8, 1'b1, 32'd99);
      tick();
      drive(8, 1'b0, 32'd77);
      n = 3;
      while (!bus8.pronto && n < 40) begin
         tick();
         n++;
      end
      check("busy_res", 32'(res(8)), 32'h0012);
      check("busy_lat", n, 9);
      pulses = 0;
      for (int i = 0; i < 14; i++) begin
         tick();
         if (bus8.pronto) pulses++;
      end
      check("busy_no_extra_pronto", pulses, 0);

      // Back-to-back with inicio held high
      drive(8, 1'b1, 32'd33);
      n = 0;
      while (!bus8.pronto && n < 40) begin
         tick();
         n++;
      end
      check("b2b_first_res", 32'(res(8)), 32'h0033);
      for (int k = 0; k < 2; k++) begin
         tick();
         n = 1;
         while (!bus8.pronto && n < 40) begin
            if (n == 5) check("b2b_hold", 32'(res(8)), 32'h0033);
            tick();
            n++;
         end
         check($sformatf("b2b_period%0d", k), n, 10);
      end
      drive(8, 1'b0, 32'd33);
      tick();
      check("b2b_stop", 32'(bus8.ocupado), 32'd0);

      // Mid-conversion reset at the 4th shift edge
      drive(8, 1'b1, 32'h9C);
      tick();
      drive(8, 1'b0, 32'h9C);
      tick();
      tick();
      tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("midrst_res", 32'(res(8)), 32'h0);
      check("midrst_flags", {30'd0, bus8.ocupado, bus8.pronto}, 32'h0);
      pulses = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (bus8.pronto) pulses++;
      end
      check("midrst_no_pronto", pulses, 0);
      convert(8, 32'd7, lat, busy);
      check("midrst_next_res", 32'(res(8)), 32'h0007);
      check("midrst_next_lat", lat, 9);

      // Parameter sweep: LARGURA=4 and LARGURA=10
      for (int v = 0; v < 16; v++) begin
         convert(4, ($urandom << 4) | 32'(v), lat, busy);
         check($sformatf("w4_v%0d_res", v), 32'(res(4)), 32'(modelo(4, v)));
         check($sformatf("w4_v%0d_lat", v), lat, 5);
      end
      for (int v = 0; v < 1024; v++) begin
         convert(10, ($urandom << 10) | 32'(v), lat, busy);
         check($sformatf("w10_v%0d_res", v), 32'(res(10)), 32'(modelo(10, v)));
         check($sformatf("w10_v%0d_lat", v), lat, 11);
      end
      convert(10, 32'h200, lat, busy);
      check("w10_min_res", 32'(res(10)), 32'h1512);
      check("w10_min_lat", lat, 11);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
